// File: rtl/keypad_pkg.sv
// Shared keypad types: frame-result encoding, key code map and the row-merge helper
// used to fold one row's column sample into the running frame result.
package keypad_pkg;
    localparam logic [3:0] KEY_NONE = 4'hF;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {FR_NONE = 2'd0, FR_KEY = 2'd1, FR_MULTI = 2'd2} frame_kind_e;

    // idx is kept zero for NONE/MULTI so whole-struct equality compares results correctly
    typedef struct packed {
        frame_kind_e kind;
        logic [3:0]  idx;
    } frame_res_t;

    localparam frame_res_t FRAME_EMPTY = '{kind: FR_NONE, idx: 4'd0};

    typedef enum logic {ST_RELEASED = 1'b0, ST_PRESSED = 1'b1} deb_state_e;

    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd13:   code = 4'h0;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    function automatic frame_res_t merge_row(input frame_res_t acc, input logic [NUM_COLS-1:0] low,
                                             input logic [1:0] row);
        frame_res_t res;
        logic [2:0] n;
        logic [1:0] col;
        res = acc;
        n   = '0;
        col = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (low[c]) begin
                n   = n + 3'd1;
                col = 2'(c);
            end
        end
        if (n > 3'd1 || (n == 3'd1 && acc.kind != FR_NONE)) res = '{kind: FR_MULTI, idx: 4'd0};
        else if (n == 3'd1) res = '{kind: FR_KEY, idx: {row, col}};
        return res;
    endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
module sync_2ff #(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] s1_q, s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates rows, classifies each scan frame, debounces whole frames
// and presents (idle, data, key_strobe) to the downstream controller.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROW_DWELL = 4,
    parameter int DEBOUNCE  = 2
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic                idle,
    output logic [3:0]          data,
    output logic                key_strobe
);
    localparam int DW = (ROW_DWELL > 1) ? $clog2(ROW_DWELL) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [NUM_COLS-1:0] col_s;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [1:0]          row_q, row_d;
    logic [NUM_ROWS-1:0] row_n_q, row_n_d;
    frame_res_t          acc_q, acc_d, prev_q, prev_d, row_res;
    logic [CW-1:0]       cnt_q, cnt_d;
    deb_state_e          state_q, state_d;
    logic                idle_q, idle_d, strobe_q, strobe_d;
    logic [3:0]          data_q, data_d;
    logic                last_dwell, frame_done, accept;

    sync_2ff #(.W(NUM_COLS), .RST_VAL('1)) u_col_sync (
        .clk  (CLK),
        .rst_n(rst_n),
        .d_i  (col_n),
        .q_o  (col_s)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q  <= '0;
            row_q    <= '0;
            row_n_q  <= ~NUM_ROWS'(1);
            acc_q    <= FRAME_EMPTY;
            prev_q   <= FRAME_EMPTY;
            cnt_q    <= '0;
            state_q  <= ST_RELEASED;
            idle_q   <= 1'b1;
            data_q   <= KEY_NONE;
            strobe_q <= 1'b0;
        end else begin
            dwell_q  <= dwell_d;
            row_q    <= row_d;
            row_n_q  <= row_n_d;
            acc_q    <= acc_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            idle_q   <= idle_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    // Scan timing and frame accumulation; the row-3 sample closes the frame
    always_comb begin
        last_dwell = (dwell_q == DW'(ROW_DWELL - 1));
        frame_done = last_dwell && (row_q == 2'(NUM_ROWS - 1));
        row_res    = merge_row(acc_q, ~col_s, row_q);
        dwell_d    = last_dwell ? '0 : dwell_q + DW'(1);
        row_d      = last_dwell ? row_q + 2'd1 : row_q;
        row_n_d    = ~(NUM_ROWS'(1) << row_d);
        acc_d      = acc_q;
        if (last_dwell) acc_d = frame_done ? FRAME_EMPTY : row_res;
    end

    // Frame-level debounce; a MULTI frame breaks any run of identical results
    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (frame_done) begin
            prev_d = row_res;
            if (row_res.kind == FR_MULTI) cnt_d = '0;
            else if (row_res == prev_q)   cnt_d = (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + CW'(1);
            else                          cnt_d = CW'(1);
        end
        accept = frame_done && (row_res.kind != FR_MULTI) && (cnt_d == CW'(DEBOUNCE));
    end

    // Key changes while held are ignored: a release must be accepted first
    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (accept && row_res.kind == FR_KEY) begin
                    state_d  = ST_PRESSED;
                    idle_d   = 1'b0;
                    data_d   = key_map(row_res.idx);
                    strobe_d = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (accept && row_res.kind == FR_NONE) begin
                    state_d = ST_RELEASED;
                    idle_d  = 1'b1;
                    data_d  = KEY_NONE;
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    assign row_n      = row_n_q;
    assign idle       = idle_q;
    assign data       = data_q;
    assign key_strobe = strobe_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench: a frame-level keypad model predicts idle/data transitions; a monitor
// compares every DUT output change, row rotation and strobe against those predictions.
module tb_keypad_scanner;
    localparam int ROW_DWELL = 4;
    localparam int DEBOUNCE  = 2;
    localparam int FRAME     = 4 * ROW_DWELL;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] col_n, row_n, data;
    logic       idle, key_strobe;
    logic [15:0] keys = '0;

    int n_pass = 0, n_chk = 0;
    int k = 0;
    int strobes = 0;
    int map_tbl[16] = '{1, 2, 3, 15, 4, 5, 6, 15, 7, 8, 9, 15, 15, 0, 15, 15};

    typedef struct {
        int         cyc;
        bit         idle;
        logic [3:0] data;
    } ev_t;
    ev_t exp_q[$];

    keypad_scanner #(.ROW_DWELL(ROW_DWELL), .DEBOUNCE(DEBOUNCE)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .col_n     (col_n),
        .row_n     (row_n),
        .idle      (idle),
        .data      (data),
        .key_strobe(key_strobe)
    );

    always #5 CLK = ~CLK;

    // Passive matrix: a column reads low when a pressed key sits on a driven row
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[4*r+c]) col_n[c] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Reference model: row r of a frame ending at edge k sees the keys present two edges
    // before its last dwell edge (synchronizer delay); results debounced per frame.
    initial begin
        bit [15:0] hist[16];
        int prev, cnt, n, idx, res, s;
        bit st;
        ev_t e;
        prev = -1; cnt = 0; st = 0;
        foreach (hist[i]) hist[i] = '0;
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) begin
                k = 0; prev = -1; cnt = 0; st = 0;
                foreach (hist[i]) hist[i] = '0;
                exp_q.delete();
            end else begin
                hist[k % 16] = keys;
                if (k % FRAME == FRAME - 1) begin
                    n = 0; idx = 0;
                    for (int r = 0; r < 4; r++) begin
                        s = (k - 2 - (3 - r) * ROW_DWELL) % 16;
                        for (int c = 0; c < 4; c++)
                            if (hist[s][4*r+c]) begin n++; idx = 4 * r + c; end
                    end
                    res = (n == 0) ? -1 : (n == 1) ? idx : 16;
                    if (res == 16) begin
                        cnt = 0; prev = 16;
                    end else begin
                        cnt = (res == prev) ? ((cnt < DEBOUNCE) ? cnt + 1 : cnt) : 1;
                        prev = res;
                        if (cnt == DEBOUNCE) begin
                            if (!st && res >= 0) begin
                                st = 1; e.cyc = k + 1; e.idle = 0; e.data = 4'(map_tbl[res]);
                                exp_q.push_back(e);
                            end else if (st && res == -1) begin
                                st = 0; e.cyc = k + 1; e.idle = 1; e.data = 4'hF;
                                exp_q.push_back(e);
                            end
                        end
                    end
                end
                k++;
            end
        end
    end

    // Monitor: samples on the falling edge, pops an expectation on every idle change
    initial begin
        bit idle_p;
        logic [3:0] data_p;
        ev_t e;
        idle_p = 1; data_p = 4'hF;
        forever begin
            @(negedge CLK);
            if (!rst_n) begin
                check("reset_row_n", row_n, 4'b1110);
                check("reset_idle", idle, 1);
                check("reset_data", data, 15);
                check("reset_strobe", key_strobe, 0);
                idle_p = 1; data_p = 4'hF;
            end else begin
                check("row_n", row_n, 15 & ~(1 << ((k / ROW_DWELL) % 4)));
                check("strobe", key_strobe, int'(idle_p && !idle));
                if (idle !== idle_p) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_idle_change: got idle=%0b data=%0h expected no change at cyc %0d", idle, data, k);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_cycle", k, e.cyc);
                        check("event_idle", idle, e.idle);
                        check("event_data", data, e.data);
                    end
                end else begin
                    check("data_stable", data, data_p);
                end
                if (key_strobe) strobes++;
                idle_p = idle; data_p = data;
            end
        end
    end

    initial begin
        int s0, mode, a, b, hold;
        cycles(3);
        rst_n = 1'b1;
        cycles(20);

        // Clean '5'
        s0 = strobes;
        keys = 16'(1 << 5);
        cycles(5 * FRAME);
        check("press5_idle", idle, 0);
        check("press5_data", data, 5);
        check("press5_strobes", strobes - s0, 1);
        keys = '0;
        cycles(3 * FRAME);
        check("rel5_idle", idle, 1);
        check("rel5_data", data, 15);

        // Bouncing '7'
        repeat (11) begin keys ^= 16'(1 << 8); cycles(3); end
        keys = 16'(1 << 8);
        cycles(4 * FRAME);
        check("bounce7_data", data, 7);
        keys = '0;
        cycles(3 * FRAME);

        // '1'+'2' together, then '2' dropped
        s0 = strobes;
        keys = 16'h0003;
        cycles(4 * FRAME);
        check("multi_idle", idle, 1);
        check("multi_strobes", strobes - s0, 0);
        keys = 16'h0001;
        cycles(4 * FRAME);
        check("drop2_data", data, 1);
        keys = '0;
        cycles(3 * FRAME);

        // Slide '3' -> '6' without release
        keys = 16'(1 << 2);
        cycles(4 * FRAME);
        check("hold3_data", data, 3);
        s0 = strobes;
        keys = 16'(1 << 6);
        cycles(4 * FRAME);
        check("slide_data", data, 3);
        check("slide_strobes", strobes - s0, 0);
        keys = '0;
        cycles(3 * FRAME);
        keys = 16'(1 << 6);
        cycles(4 * FRAME);
        check("press6_data", data, 6);
        check("press6_strobes", strobes - s0, 1);
        keys = '0;
        cycles(3 * FRAME);

        // '#', then reset mid-hold
        keys = 16'(1 << 14);
        cycles(4 * FRAME);
        check("hash_idle", idle, 0);
        check("hash_data", data, 15);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_idle", idle, 1);
        check("async_rst_row_n", row_n, 4'b1110);
        cycles(2);
        rst_n = 1'b1;
        s0 = strobes;
        cycles(4 * FRAME);
        check("rehash_idle", idle, 0);
        check("rehash_strobes", strobes - s0, 1);
        keys = '0;
        cycles(3 * FRAME);

        // Random keypad activity
        repeat (60) begin
            mode = $urandom_range(0, 9);
            a = $urandom_range(0, 15);
            b = $urandom_range(0, 15);
            hold = $urandom_range(4, 70);
            if (mode < 2) keys = '0;
            else if (mode < 8) keys = 16'(1 << a);
            else if (mode == 8) keys = 16'((1 << a) | (1 << b));
            else begin
                repeat ($urandom_range(2, 8)) begin keys ^= 16'(1 << a); cycles($urandom_range(1, 5)); end
            end
            cycles(hold);
        end
        keys = '0;
        cycles(4 * FRAME);
        check("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
